dut_output_monitor: RTL and testbench
=====================================

Name: dut_output_monitor

Overview:
Passive observer on the DUT output side of the simple DUT interface. It samples o_bitSignal1, o_bitSignal2, o_bit32Signal1 and o_bit8Signal2 every clock. It packs qualifying samples into timestamped records and buffers them in an internal FIFO. The bench or scoreboard drains the records over a valid/ready pop port; this block is the counterpart of the input-side driving path.

Parameters:
DEPTH, 16, FIFO depth in records; power of 2, >= 2
TS_W, 16, timestamp counter width
CNT_W, 16, drop counter width

Ports:
clk  input  1  clock
rst  input  1  reset
en  input  1  monitoring enable
capture_all  input  1  1: record every enabled cycle; 0: record on change only
clear  input  1  flush FIFO, clear overflow/drop_count/history
o_bitSignal1  input  1  observed DUT output
o_bitSignal2  input  1  observed DUT output
o_bit32Signal1  input  32  observed DUT output
o_bit8Signal2  input  8  observed DUT output
rec_valid  output  1  head record available
rec_ready  input  1  consumer accepts head record
rec_ts  output  TS_W  timestamp of head record
rec_bit1  output  1  head record o_bitSignal1
rec_bit2  output  1  head record o_bitSignal2
rec_bit32  output  32  head record o_bit32Signal1
rec_bit8  output  8  head record o_bit8Signal2
fifo_level  output  $clog2(DEPTH)+1  records currently stored
overflow  output  1  sticky: at least one record dropped
drop_count  output  CNT_W  dropped records, saturating

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset: ts=0, FIFO empty, rec_valid=0, fifo_level=0, overflow=0, drop_count=0, history invalid. rec_* data is 0 after reset, otherwise don't-care while rec_valid=0.
- Timestamp ts: increments every cycle when not in reset, independent of en/clear. Wraps 2^TS_W-1 -> 0.
- Sample S = {o_bitSignal1, o_bitSignal2, o_bit32Signal1, o_bit8Signal2} taken at the clock edge.
- History: prev/prev_valid.
  - When en=1: prev<=S and prev_valid<=1.
  - When en=0: prev_valid<=0.
  - clear also forces prev_valid<=0.
- Event in cycle N: en=1 and (capture_all=1 or prev_valid=0 or S!=prev). Record = {ts at cycle N, S}.
- Push latency: an event in cycle N into an empty FIFO gives rec_valid=1 in cycle N+1. There is no combinational bypass.
- Pop: occurs when rec_valid & rec_ready. The next record appears at the head the following cycle. Records are delivered in strict FIFO order. rec_* stays stable while rec_valid=1 and rec_ready=0.
- Full handling:
  - An event with fifo_level=DEPTH and no pop in the same cycle is dropped.
  - On a drop: overflow<=1 and drop_count increments, saturating at all-ones.
  - Push and pop in the same cycle while full is legal: no drop, level stays DEPTH.
- Push and pop in the same cycle with level=1: level stays 1, and the new record is at the head next cycle.
- fifo_level: registered, updated the same edge as push/pop.
- Priority is rst > clear > normal operation.
  - clear in cycle N: FIFO empties, rec_valid=0, overflow=0, drop_count=0, prev_valid=0.
  - Any event or pop in cycle N is discarded; ts is unaffected.
- Reset mid-operation discards all stored records and restarts ts from 0.
- Pointers: log2(DEPTH) bits, naturally wrapping. Storage is a simple register array.

Test Plan:
1. rst 2 cycles, then en=1, capture_all=0, outputs held at 0, rec_ready=1 for 10 cycles -> exactly one record, with ts equal to the first enabled cycle's ts and all data 0.
2. capture_all=0, rec_ready=1; o_bit32Signal1=0xDEADBEEF at ts=5, held at ts=6, o_bit8Signal2=0xA5 at ts=7 -> exactly two records: {ts5, 32'hDEADBEEF, 8'h00} and {ts7, 32'hDEADBEEF, 8'hA5}.
3. DEPTH=16, capture_all=1, rec_ready=0, en for 20 cycles -> fifo_level=16, overflow=1, drop_count=4. Then rec_ready=1 -> 16 records drain in order with consecutive ts values (first 16 enabled cycles).
4. FIFO full and rec_ready=1 with capture_all=1 for 10 cycles -> one record per cycle, fifo_level stays 16, drop_count unchanged.
5. fifo_level=8 and overflow=1, pulse clear -> next cycle level=0, rec_valid=0, overflow=0, drop_count=0. With capture_all=0 and unchanged outputs, exactly one record on the next enabled cycle.
6. TS_W=4, capture_all=1, rec_ready=1, 20 enabled cycles -> rec_ts wraps 15 -> 0 with no gaps. rst asserted mid-stream -> rec_valid=0 and fifo_level=0 next cycle, and ts restarts at 0.

Source files
------------

// File: rtl/dut_output_monitor.sv
// Passive monitor for the DUT output side. Qualifying samples are stamped with
// a free-running timestamp and queued in a register FIFO, which is drained over valid/ready.
module dut_output_monitor #(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       capture_all,
  input  logic                       clear,
  input  logic                       o_bitSignal1,
  input  logic                       o_bitSignal2,
  input  logic [31:0]                o_bit32Signal1,
  input  logic [7:0]                 o_bit8Signal2,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TS_W-1:0]            rec_ts,
  output logic                       rec_bit1,
  output logic                       rec_bit2,
  output logic [31:0]                rec_bit32,
  output logic [7:0]                 rec_bit8,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int SW    = 42;
  localparam int RW    = TS_W + SW;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [TS_W-1:0] ts;
  logic [SW-1:0]   sample, prev;
  logic            prev_valid;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            event_hit, push, pop, drop, full;

  assign sample    = {o_bitSignal1, o_bitSignal2, o_bit32Signal1, o_bit8Signal2};
  assign full      = (fifo_level == FULL_LVL);
  assign rec_valid = (fifo_level != '0);
  assign pop       = rec_valid & rec_ready;
  assign event_hit = en & (capture_all | ~prev_valid | (sample != prev));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push      = event_hit & (~full | pop);
  assign drop      = event_hit & full & ~pop;

  assign {rec_ts, rec_bit1, rec_bit2, rec_bit32, rec_bit8} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (clear) begin
        prev_valid <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        prev_valid <= en;
        if (en) prev <= sample;
        if (push) begin
          mem[wr_ptr] <= {ts, sample};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      fifo_level <= fifo_level + 1'b1;
        else if (!push && pop) fifo_level <= fifo_level - 1'b1;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dut_output_monitor.sv
// Directed bench for dut_output_monitor: default instance plus a 4-bit timestamp
// instance sharing the same stimulus to exercise timestamp wrap.
module tb_dut_output_monitor;
  logic clk = 1'b0;
  logic rst, en, capture_all, clear, rec_ready;
  logic b1, b2;
  logic [31:0] b32;
  logic [7:0]  b8;

  logic        rec_valid, rec_bit1, rec_bit2, overflow;
  logic [15:0] rec_ts, drop_count;
  logic [31:0] rec_bit32;
  logic [7:0]  rec_bit8;
  logic [4:0]  fifo_level;

  logic        rec_valid1, rec_bit1_1, rec_bit2_1, overflow1;
  logic [3:0]  rec_ts1;
  logic [15:0] drop_count1;
  logic [31:0] rec_bit32_1;
  logic [7:0]  rec_bit8_1;
  logic [4:0]  fifo_level1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dut_output_monitor #(.DEPTH(16), .TS_W(16), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en), .capture_all(capture_all), .clear(clear),
    .o_bitSignal1(b1), .o_bitSignal2(b2), .o_bit32Signal1(b32), .o_bit8Signal2(b8),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts),
    .rec_bit1(rec_bit1), .rec_bit2(rec_bit2), .rec_bit32(rec_bit32), .rec_bit8(rec_bit8),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
  );

  dut_output_monitor #(.DEPTH(16), .TS_W(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en), .capture_all(capture_all), .clear(clear),
    .o_bitSignal1(b1), .o_bitSignal2(b2), .o_bit32Signal1(b32), .o_bit8Signal2(b8),
    .rec_valid(rec_valid1), .rec_ready(rec_ready), .rec_ts(rec_ts1),
    .rec_bit1(rec_bit1_1), .rec_bit2(rec_bit2_1), .rec_bit32(rec_bit32_1), .rec_bit8(rec_bit8_1),
    .fifo_level(fifo_level1), .overflow(overflow1), .drop_count(drop_count1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; on return the current cycle carries ts = 0.
  task automatic do_reset();
    rst = 1'b1; en = 1'b0; capture_all = 1'b0; clear = 1'b0; rec_ready = 1'b0;
    b1 = 1'b0; b2 = 1'b0; b32 = '0; b8 = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; capture_all = 1'b0; clear = 1'b0; rec_ready = 1'b0;
    b1 = 1'b0; b2 = 1'b0; b32 = '0; b8 = '0;
    step(); step();
    n_cmp++; if (rec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", rec_valid); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf got %b/%0d exp 0/0", overflow, drop_count); end
    n_cmp++; if ({rec_ts, rec_bit1, rec_bit2, rec_bit32, rec_bit8} !== 58'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", {rec_ts, rec_bit32, rec_bit8}); end
    n_cmp++; if (rec_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_valid_u1 got %b exp 0", rec_valid1); end
  endtask

  task automatic test_first_record();
    int cnt = 0;
    logic [15:0] got_ts = 16'hFFFF;
    logic [41:0] got_d = '1;
    rst = 1'b0; en = 1'b1; rec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (rec_valid) begin cnt++; got_ts = rec_ts; got_d = {rec_bit1, rec_bit2, rec_bit32, rec_bit8}; end
      step();
    end
    en = 1'b0;
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL first_count got %0d exp 1", cnt); end
    n_cmp++; if (got_ts !== 16'd0) begin n_err++; $display("FAIL first_ts got %0d exp 0", got_ts); end
    n_cmp++; if (got_d !== 42'd0) begin n_err++; $display("FAIL first_data got %h exp 0", got_d); end
  endtask

  task automatic test_change();
    int cnt = 0;
    logic [15:0] r_ts [4];
    logic [31:0] r_32 [4];
    logic [7:0]  r_8  [4];
    do_reset();
    rec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      en  = (c >= 5);
      b32 = (c >= 5) ? 32'hDEADBEEF : 32'h0;
      b8  = (c >= 7) ? 8'hA5 : 8'h00;
      if (rec_valid) begin
        if (cnt < 4) begin r_ts[cnt] = rec_ts; r_32[cnt] = rec_bit32; r_8[cnt] = rec_bit8; end
        cnt++;
      end
      step();
    end
    en = 1'b0;
    n_cmp++; if (cnt !== 2) begin n_err++; $display("FAIL change_count got %0d exp 2", cnt); end
    n_cmp++; if (r_ts[0] !== 16'd5 || r_32[0] !== 32'hDEADBEEF || r_8[0] !== 8'h00)
      begin n_err++; $display("FAIL change_rec0 got %0d/%h/%h exp 5/deadbeef/00", r_ts[0], r_32[0], r_8[0]); end
    n_cmp++; if (r_ts[1] !== 16'd7 || r_32[1] !== 32'hDEADBEEF || r_8[1] !== 8'hA5)
      begin n_err++; $display("FAIL change_rec1 got %0d/%h/%h exp 7/deadbeef/a5", r_ts[1], r_32[1], r_8[1]); end
  endtask

  task automatic test_overflow();
    do_reset();
    capture_all = 1'b1;
    for (int c = 0; c < 20; c++) begin en = 1'b1; b8 = 8'(c); step(); end
    en = 1'b0;
    n_cmp++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d exp 16", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_cmp++; if (drop_count !== 16'd4) begin n_err++; $display("FAIL ovf_drops got %0d exp 4", drop_count); end
    rec_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (rec_valid !== 1'b1 || rec_ts !== 16'(k) || rec_bit8 !== 8'(k))
        begin n_err++; $display("FAIL ovf_drain%0d got v%b ts%0d d%0d exp ts%0d", k, rec_valid, rec_ts, rec_bit8, k); end
      step();
    end
    n_cmp++; if (rec_valid !== 1'b0 || fifo_level !== 5'd0) begin n_err++; $display("FAIL ovf_empty got v%b lvl%0d exp 0/0", rec_valid, fifo_level); end
    rec_ready = 1'b0;
  endtask

  task automatic test_full_stream();
    do_reset();
    capture_all = 1'b1;
    for (int c = 0; c < 16; c++) begin en = 1'b1; b8 = 8'(c); step(); end
    rec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b8 = 8'(16 + k);
      n_cmp++; if (rec_valid !== 1'b1 || rec_ts !== 16'(k) || rec_bit8 !== 8'(k))
        begin n_err++; $display("FAIL stream_head%0d got v%b ts%0d exp ts%0d", k, rec_valid, rec_ts, k); end
      step();
      n_cmp++; if (fifo_level !== 5'd16 || drop_count !== 16'd0)
        begin n_err++; $display("FAIL stream_lvl%0d got lvl%0d drop%0d exp 16/0", k, fifo_level, drop_count); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf got %b exp 0", overflow); end
    en = 1'b0; rec_ready = 1'b0;
  endtask

  task automatic test_clear();
    int cnt = 0;
    logic [15:0] got_ts = 16'hFFFF;
    do_reset();
    capture_all = 1'b1; en = 1'b1;
    for (int c = 0; c < 20; c++) step();
    capture_all = 1'b0; rec_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    n_cmp++; if (fifo_level !== 5'd8 || overflow !== 1'b1)
      begin n_err++; $display("FAIL clr_pre got lvl%0d ovf%b exp 8/1", fifo_level, overflow); end
    rec_ready = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++; if (fifo_level !== 5'd0 || rec_valid !== 1'b0)
      begin n_err++; $display("FAIL clr_fifo got lvl%0d v%b exp 0/0", fifo_level, rec_valid); end
    n_cmp++; if (overflow !== 1'b0 || drop_count !== 16'd0)
      begin n_err++; $display("FAIL clr_ovf got %b/%0d exp 0/0", overflow, drop_count); end
    rec_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (rec_valid) begin cnt++; got_ts = rec_ts; end
      step();
    end
    n_cmp++; if (cnt !== 1 || got_ts !== 16'd29)
      begin n_err++; $display("FAIL clr_rearm got cnt%0d ts%0d exp 1/29", cnt, got_ts); end
    en = 1'b0; rec_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    logic [3:0] exp_ts;
    int bad = 0;
    do_reset();
    capture_all = 1'b1; rec_ready = 1'b1;
    for (int c = 0; c < 21; c++) begin
      en = (c < 20);
      if (c >= 1) begin
        exp_ts = 4'((c - 1) % 16);
        if (rec_valid1 !== 1'b1 || rec_ts1 !== exp_ts) bad++;
      end
      step();
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL wrap_seq got %0d bad records exp 0", bad); end
    en = 1'b1;
    for (int c = 0; c < 3; c++) step();
    rst = 1'b1;
    step();
    n_cmp++; if (rec_valid1 !== 1'b0 || fifo_level1 !== 5'd0)
      begin n_err++; $display("FAIL wrap_rst got v%b lvl%0d exp 0/0", rec_valid1, fifo_level1); end
    rst = 1'b0;
    step();
    n_cmp++; if (rec_valid1 !== 1'b1 || rec_ts1 !== 4'd0)
      begin n_err++; $display("FAIL wrap_restart got v%b ts%0d exp 1/0", rec_valid1, rec_ts1); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_change();
    test_overflow();
    test_full_stream();
    test_clear();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
